// File: rtl/cp0_reg_pkg.sv
// Shared CP0 definitions: register numbers, exception types and codes,
// constant register values, and the exception decode helper.
package cp0_reg_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned INT_W  = 6;
  localparam int unsigned CODE_W = 5;

  // CP0 register numbers
  localparam logic [ADDR_W-1:0] REG_COUNT   = 5'd9;
  localparam logic [ADDR_W-1:0] REG_COMPARE = 5'd11;
  localparam logic [ADDR_W-1:0] REG_STATUS  = 5'd12;
  localparam logic [ADDR_W-1:0] REG_CAUSE   = 5'd13;
  localparam logic [ADDR_W-1:0] REG_EPC     = 5'd14;
  localparam logic [ADDR_W-1:0] REG_PRID    = 5'd15;
  localparam logic [ADDR_W-1:0] REG_CONFIG  = 5'd16;

  // excepttype_i encodings presented by MEM
  localparam logic [DATA_W-1:0] EXC_INTERRUPT = 32'h0000_0001;
  localparam logic [DATA_W-1:0] EXC_SYSCALL   = 32'h0000_0008;
  localparam logic [DATA_W-1:0] EXC_RI        = 32'h0000_000a;
  localparam logic [DATA_W-1:0] EXC_OV        = 32'h0000_000c;
  localparam logic [DATA_W-1:0] EXC_TRAP      = 32'h0000_000d;
  localparam logic [DATA_W-1:0] EXC_ERET      = 32'h0000_000e;

  // Cause.ExcCode values
  localparam logic [CODE_W-1:0] CODE_INT  = 5'h00;
  localparam logic [CODE_W-1:0] CODE_SYS  = 5'h08;
  localparam logic [CODE_W-1:0] CODE_RI   = 5'h0a;
  localparam logic [CODE_W-1:0] CODE_OV   = 5'h0c;
  localparam logic [CODE_W-1:0] CODE_TRAP = 5'h0d;

  // Constant and reset values
  localparam logic [DATA_W-1:0] PRID_VAL    = 32'h004C_0102;
  localparam logic [DATA_W-1:0] CONFIG_VAL  = 32'h0000_8000;
  localparam logic [DATA_W-1:0] STATUS_RST  = 32'h1000_0000;
  // Software-writable Cause bits: IV, WP, IP1:0
  localparam logic [DATA_W-1:0] CAUSE_WMASK = 32'h00C0_0300;

  localparam int unsigned STATUS_EXL = 1;

  typedef struct packed {
    logic              take;  // exception that saves EPC and sets EXL
    logic              eret;  // return from exception
    logic [CODE_W-1:0] code;  // ExcCode to record when take is set
  } exc_dec_t;

  // Classify excepttype_i; unlisted nonzero values decode to no action.
  function automatic exc_dec_t exc_decode(input logic [DATA_W-1:0] t);
    exc_dec_t d;
    d = '{take: 1'b0, eret: 1'b0, code: CODE_INT};
    case (t)
      EXC_INTERRUPT: d = '{take: 1'b1, eret: 1'b0, code: CODE_INT};
      EXC_SYSCALL:   d = '{take: 1'b1, eret: 1'b0, code: CODE_SYS};
      EXC_RI:        d = '{take: 1'b1, eret: 1'b0, code: CODE_RI};
      EXC_OV:        d = '{take: 1'b1, eret: 1'b0, code: CODE_OV};
      EXC_TRAP:      d = '{take: 1'b1, eret: 1'b0, code: CODE_TRAP};
      EXC_ERET:      d = '{take: 1'b0, eret: 1'b1, code: CODE_INT};
      default:       d = '{take: 1'b0, eret: 1'b0, code: CODE_INT};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// CP0 access bundle between the pipeline (master) and the CP0 block (slave).
// Carries MTC0 write, MFC0 read, interrupt lines, exception info and the
// live register values.
interface cp0_reg_if;
  import cp0_reg_pkg::*;

  logic                  we_i;
  logic [ADDR_W-1:0]     waddr_i;
  logic [DATA_W-1:0]     data_i;
  logic [ADDR_W-1:0]     raddr_i;
  logic [INT_W-1:0]      int_i;
  logic [DATA_W-1:0]     excepttype_i;
  logic [DATA_W-1:0]     current_pc_i;

  logic [DATA_W-1:0]     data_o;
  logic [DATA_W-1:0]     count_o;
  logic [DATA_W-1:0]     compare_o;
  logic [DATA_W-1:0]     status_o;
  logic [DATA_W-1:0]     cause_o;
  logic [DATA_W-1:0]     epc_o;
  logic                  timer_int_o;

  modport master (
    output we_i, waddr_i, data_i, raddr_i, int_i, excepttype_i, current_pc_i,
    input  data_o, count_o, compare_o, status_o, cause_o, epc_o, timer_int_o
  );

  modport slave (
    input  we_i, waddr_i, data_i, raddr_i, int_i, excepttype_i, current_pc_i,
    output data_o, count_o, compare_o, status_o, cause_o, epc_o, timer_int_o
  );

endinterface

// File: rtl/cp0_reg.sv
// MIPS CP0 register file: Count/Compare timer, Status, Cause, EPC, and
// constant PRId/Config. Exception/ERET updates take priority over MTC0
// writes on overlapping fields.
// Ports: clk, rst (async active-high), bus (cp0_reg_if.slave: write, read,
// interrupts, exception info in; read data, live registers, timer irq out).
module cp0_reg
  import cp0_reg_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  cp0_reg_if.slave  bus
);

  logic [DATA_W-1:0] count_q,   count_d;
  logic [DATA_W-1:0] compare_q, compare_d;
  logic [DATA_W-1:0] status_q,  status_d;
  logic [DATA_W-1:0] cause_q,   cause_d;
  logic [DATA_W-1:0] epc_q,     epc_d;
  logic              timer_q,   timer_d;
  logic              wr_compare;
  exc_dec_t          dec;

  // Next-state: MTC0 write first, then hardware fields, then exception override
  always_comb begin
    dec        = exc_decode(bus.excepttype_i);
    count_d    = count_q + DATA_W'(1);
    compare_d  = compare_q;
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    wr_compare = 1'b0;

    if (bus.we_i) begin
      case (bus.waddr_i)
        REG_COUNT:   count_d = bus.data_i;
        REG_COMPARE: begin
          compare_d  = bus.data_i;
          wr_compare = 1'b1;
        end
        REG_STATUS:  status_d = bus.data_i;
        REG_CAUSE:   cause_d  = (cause_q & ~CAUSE_WMASK) | (bus.data_i & CAUSE_WMASK);
        REG_EPC:     epc_d    = bus.data_i;
        default:     ;
      endcase
    end

    cause_d[15:10] = bus.int_i;

    if (dec.take) begin
      epc_d                = bus.current_pc_i;
      status_d[STATUS_EXL] = 1'b1;
      cause_d[6:2]         = dec.code;
    end else if (dec.eret) begin
      status_d[STATUS_EXL] = 1'b0;
    end

    // Compare write clears the request even if equality holds this cycle
    if (wr_compare) begin
      timer_d = 1'b0;
    end else if ((compare_q != '0) && (count_q == compare_q)) begin
      timer_d = 1'b1;
    end else begin
      timer_d = timer_q;
    end
  end

  // Register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      status_q  <= STATUS_RST;
      cause_q   <= '0;
      epc_q     <= '0;
      timer_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      timer_q   <= timer_d;
    end
  end

  // Combinational MFC0 read, no write bypass
  always_comb begin
    case (bus.raddr_i)
      REG_COUNT:   bus.data_o = count_q;
      REG_COMPARE: bus.data_o = compare_q;
      REG_STATUS:  bus.data_o = status_q;
      REG_CAUSE:   bus.data_o = cause_q;
      REG_EPC:     bus.data_o = epc_q;
      REG_PRID:    bus.data_o = PRID_VAL;
      REG_CONFIG:  bus.data_o = CONFIG_VAL;
      default:     bus.data_o = '0;
    endcase
  end

  assign bus.count_o     = count_q;
  assign bus.compare_o   = compare_q;
  assign bus.status_o    = status_q;
  assign bus.cause_o     = cause_q;
  assign bus.epc_o       = epc_q;
  assign bus.timer_int_o = timer_q;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed testbench for cp0_reg: reset, timer, masked Cause write,
// exceptions/ERET, write-vs-exception collision, Count wrap, reads,
// interrupt sampling and asynchronous reset mid-update.
module tb_cp0_reg;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cp0_reg_if bus ();

  cp0_reg u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1);
  end

  // Advance to 1 time unit past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we_i         = 1'b0;
    bus.waddr_i      = '0;
    bus.data_i       = '0;
    bus.excepttype_i = '0;
    bus.current_pc_i = '0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we_i    = 1'b1;
    bus.waddr_i = a;
    bus.data_i  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.raddr_i = '0;
    bus.int_i   = '0;
    #2;
    checks++; if (bus.count_o !== 32'h0) begin errors++; $display("FAIL rst_count got %h exp %h", bus.count_o, 32'h0); end
    checks++; if (bus.status_o !== 32'h1000_0000) begin errors++; $display("FAIL rst_status got %h exp %h", bus.status_o, 32'h1000_0000); end
    checks++; if (bus.timer_int_o !== 1'b0) begin errors++; $display("FAIL rst_timer got %b exp 0", bus.timer_int_o); end
    checks++; if (bus.cause_o !== 32'h0 || bus.epc_o !== 32'h0 || bus.compare_o !== 32'h0) begin errors++; $display("FAIL rst_regs got cause %h epc %h cmp %h exp 0", bus.cause_o, bus.epc_o, bus.compare_o); end
    tick();
    tick();
    checks++; if (bus.count_o !== 32'h0) begin errors++; $display("FAIL rst_hold got %h exp %h", bus.count_o, 32'h0); end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (bus.count_o !== 32'(i)) begin errors++; $display("FAIL rst_count_inc%0d got %h exp %h", i, bus.count_o, 32'(i)); end
    end
    // Count passed Compare==0 at the first edge; no interrupt when Compare is 0
    checks++; if (bus.timer_int_o !== 1'b0) begin errors++; $display("FAIL rst_cmp0_timer got %b exp 0", bus.timer_int_o); end
  endtask

  task automatic test_timer();
    mtc0(5'd9, 32'h10);
    tick();
    checks++; if (bus.count_o !== 32'h10) begin errors++; $display("FAIL tmr_count_wr got %h exp %h", bus.count_o, 32'h10); end
    mtc0(5'd11, 32'h20);
    tick();
    idle();
    checks++; if (bus.compare_o !== 32'h20 || bus.count_o !== 32'h11) begin errors++; $display("FAIL tmr_cmp_wr got cmp %h cnt %h exp 20 11", bus.compare_o, bus.count_o); end
    repeat (15) tick();
    checks++; if (bus.count_o !== 32'h20 || bus.timer_int_o !== 1'b0) begin errors++; $display("FAIL tmr_at_eq got cnt %h irq %b exp 20 0", bus.count_o, bus.timer_int_o); end
    tick();
    checks++; if (bus.timer_int_o !== 1'b1) begin errors++; $display("FAIL tmr_rise got %b exp 1", bus.timer_int_o); end
    repeat (3) tick();
    checks++; if (bus.timer_int_o !== 1'b1) begin errors++; $display("FAIL tmr_hold got %b exp 1", bus.timer_int_o); end
    mtc0(5'd11, 32'h40);
    tick();
    idle();
    checks++; if (bus.timer_int_o !== 1'b0 || bus.compare_o !== 32'h40) begin errors++; $display("FAIL tmr_clear got irq %b cmp %h exp 0 40", bus.timer_int_o, bus.compare_o); end
  endtask

  task automatic test_cause_mask();
    bus.int_i = '0;
    mtc0(5'd13, 32'hFFFF_FFFF);
    tick();
    idle();
    checks++; if (bus.cause_o !== 32'h00C0_0300) begin errors++; $display("FAIL cause_mask got %h exp %h", bus.cause_o, 32'h00C0_0300); end
    mtc0(5'd13, 32'h0);
    tick();
    idle();
    checks++; if (bus.cause_o !== 32'h0) begin errors++; $display("FAIL cause_clr got %h exp %h", bus.cause_o, 32'h0); end
  endtask

  task automatic test_exception();
    bus.excepttype_i = 32'h8;
    bus.current_pc_i = 32'hBFC0_0100;
    tick();
    idle();
    checks++; if (bus.epc_o !== 32'hBFC0_0100) begin errors++; $display("FAIL exc_epc got %h exp %h", bus.epc_o, 32'hBFC0_0100); end
    checks++; if (bus.status_o !== 32'h1000_0002) begin errors++; $display("FAIL exc_status got %h exp %h", bus.status_o, 32'h1000_0002); end
    checks++; if (bus.cause_o !== 32'h0000_0020) begin errors++; $display("FAIL exc_cause got %h exp %h", bus.cause_o, 32'h0000_0020); end
    bus.excepttype_i = 32'he;
    bus.current_pc_i = 32'h0000_0444;
    tick();
    idle();
    checks++; if (bus.status_o !== 32'h1000_0000) begin errors++; $display("FAIL eret_status got %h exp %h", bus.status_o, 32'h1000_0000); end
    checks++; if (bus.epc_o !== 32'hBFC0_0100 || bus.cause_o !== 32'h0000_0020) begin errors++; $display("FAIL eret_other got epc %h cause %h exp bfc00100 20", bus.epc_o, bus.cause_o); end
    bus.excepttype_i = 32'h5;
    bus.current_pc_i = 32'h0000_0999;
    tick();
    idle();
    checks++; if (bus.epc_o !== 32'hBFC0_0100 || bus.status_o !== 32'h1000_0000 || bus.cause_o !== 32'h0000_0020) begin errors++; $display("FAIL exc_ignored got epc %h st %h cause %h", bus.epc_o, bus.status_o, bus.cause_o); end
  endtask

  task automatic test_collision();
    mtc0(5'd14, 32'h1234);
    bus.excepttype_i = 32'ha;
    bus.current_pc_i = 32'h80;
    tick();
    idle();
    checks++; if (bus.epc_o !== 32'h80) begin errors++; $display("FAIL col_epc got %h exp %h", bus.epc_o, 32'h80); end
    checks++; if (bus.cause_o !== 32'h28 || bus.status_o !== 32'h1000_0002) begin errors++; $display("FAIL col_ri got cause %h st %h exp 28 10000002", bus.cause_o, bus.status_o); end
    // Status write with interrupt exception: EXL forced, other bits from write
    mtc0(5'd12, 32'h0000_FF00);
    bus.excepttype_i = 32'h1;
    bus.current_pc_i = 32'h44;
    tick();
    idle();
    checks++; if (bus.status_o !== 32'h0000_FF02) begin errors++; $display("FAIL col_status got %h exp %h", bus.status_o, 32'h0000_FF02); end
    checks++; if (bus.epc_o !== 32'h44 || bus.cause_o !== 32'h0) begin errors++; $display("FAIL col_int got epc %h cause %h exp 44 0", bus.epc_o, bus.cause_o); end
  endtask

  task automatic test_wrap();
    mtc0(5'd9, 32'hFFFF_FFFF);
    tick();
    idle();
    checks++; if (bus.count_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_max got %h exp %h", bus.count_o, 32'hFFFF_FFFF); end
    tick();
    checks++; if (bus.count_o !== 32'h0) begin errors++; $display("FAIL wrap_zero got %h exp %h", bus.count_o, 32'h0); end
  endtask

  task automatic test_reads();
    bus.raddr_i = 5'd15; #1;
    checks++; if (bus.data_o !== 32'h004C_0102) begin errors++; $display("FAIL rd_prid got %h exp %h", bus.data_o, 32'h004C_0102); end
    bus.raddr_i = 5'd16; #1;
    checks++; if (bus.data_o !== 32'h0000_8000) begin errors++; $display("FAIL rd_config got %h exp %h", bus.data_o, 32'h0000_8000); end
    bus.raddr_i = 5'd3; #1;
    checks++; if (bus.data_o !== 32'h0) begin errors++; $display("FAIL rd_unmapped got %h exp %h", bus.data_o, 32'h0); end
    bus.raddr_i = 5'd14; #1;
    checks++; if (bus.data_o !== 32'h44) begin errors++; $display("FAIL rd_epc got %h exp %h", bus.data_o, 32'h44); end
    mtc0(5'd9, 32'h100);
    tick();
    idle();
    bus.raddr_i = 5'd9; #1;
    checks++; if (bus.data_o !== 32'h100) begin errors++; $display("FAIL rd_count got %h exp %h", bus.data_o, 32'h100); end
    mtc0(5'd15, 32'h0);
    tick();
    mtc0(5'd3, 32'hFFFF);
    tick();
    idle();
    bus.raddr_i = 5'd15; #1;
    checks++; if (bus.data_o !== 32'h004C_0102) begin errors++; $display("FAIL rd_prid_wr got %h exp %h", bus.data_o, 32'h004C_0102); end
    bus.raddr_i = 5'd3; #1;
    checks++; if (bus.data_o !== 32'h0) begin errors++; $display("FAIL rd_unmapped_wr got %h exp %h", bus.data_o, 32'h0); end
  endtask

  task automatic test_interrupt();
    tick();
    bus.int_i = 6'h21;
    checks++; if (bus.cause_o[15:10] !== 6'h00) begin errors++; $display("FAIL int_latency got %h exp %h", bus.cause_o[15:10], 6'h00); end
    tick();
    checks++; if (bus.cause_o !== 32'h0000_8400) begin errors++; $display("FAIL int_ip got %h exp %h", bus.cause_o, 32'h0000_8400); end
    bus.int_i = '0;
    tick();
    checks++; if (bus.cause_o !== 32'h0) begin errors++; $display("FAIL int_drop got %h exp %h", bus.cause_o, 32'h0); end
  endtask

  task automatic test_reset_mid();
    mtc0(5'd9, 32'h55);
    bus.excepttype_i = 32'h8;
    bus.current_pc_i = 32'h1000;
    bus.int_i        = 6'h3F;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.count_o !== 32'h0 || bus.epc_o !== 32'h0 || bus.status_o !== 32'h1000_0000 || bus.compare_o !== 32'h0) begin errors++; $display("FAIL rstmid_async got cnt %h epc %h st %h cmp %h", bus.count_o, bus.epc_o, bus.status_o, bus.compare_o); end
    tick();
    idle();
    bus.int_i = '0;
    checks++; if (bus.count_o !== 32'h0 || bus.epc_o !== 32'h0 || bus.cause_o !== 32'h0) begin errors++; $display("FAIL rstmid_hold got cnt %h epc %h cause %h exp 0", bus.count_o, bus.epc_o, bus.cause_o); end
    rst = 1'b0;
    tick();
    checks++; if (bus.count_o !== 32'h1 || bus.epc_o !== 32'h0 || bus.timer_int_o !== 1'b0) begin errors++; $display("FAIL rstmid_first got cnt %h epc %h irq %b exp 1 0 0", bus.count_o, bus.epc_o, bus.timer_int_o); end
    tick();
    checks++; if (bus.count_o !== 32'h2) begin errors++; $display("FAIL rstmid_second got %h exp %h", bus.count_o, 32'h2); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_timer();
    test_cause_mask();
    test_exception();
    test_collision();
    test_wrap();
    test_reads();
    test_interrupt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
